// File: rtl/jk_excitation_driver.sv
// Writer for a bank of JK flip-flops: turns a target word into one cycle of J/K
// excitation, reads the bank back, and re-drives a bounded number of times.
module jk_excitation_driver #(
  parameter int WIDTH       = 8,
  parameter bit TOGGLE_PREF = 1'b0,
  parameter int MAX_RETRY   = 2,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    flip_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [2:0]       retry_q, retry_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CW-1:0]    flip_cnt_q, flip_cnt_d;

  // Excitation table: unchanged bits get 00 so the bank holds them.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] chg;
    chg = cur ^ tgt;
    if (TOGGLE_PREF) return {chg, chg};
    return {~cur & tgt, cur & ~tgt};
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign tgt_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign flip_cnt  = flip_cnt_q;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    j_d        = '0;
    k_d        = '0;
    retry_d    = retry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    flip_cnt_d = flip_cnt_q;
    case (state_q)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          tgt_d      = tgt_data;
          retry_d    = '0;
          {j_d, k_d} = excite(q_fb, tgt_data);
          flip_cnt_d = popcount(q_fb ^ tgt_data);
          state_d    = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (q_fb == tgt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (retry_q < MAX_R) begin
          // Recompute from the current readback rather than replaying the old drive.
          retry_d    = retry_q + 3'd1;
          {j_d, k_d} = excite(q_fb, tgt_q);
          state_d    = DRIVE;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      j_q        <= '0;
      k_q        <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      flip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      k_q        <= k_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      flip_cnt_q <= flip_cnt_d;
    end
    tgt_q <= tgt_d;
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two drivers (set/reset and toggle excitation),
// each wired to a behavioural 8-bit JK bank; completions checked by a scoreboard.
module tb_jk_excitation_driver;

  typedef struct {
    bit         is_err;
    logic [7:0] q;
    logic [3:0] fc;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tgt_valid, tgt_valid_t;
  logic [7:0] tgt_data, tgt_data_t;
  logic       tgt_ready, tgt_ready_t;
  logic [7:0] j, k, j_t, k_t;
  logic [7:0] q_fb, q_fb_t;
  logic       busy, busy_t, done, done_t, err, err_t;
  logic [3:0] flip_cnt, flip_cnt_t;

  logic [7:0] bank, bank_t, stuck;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       sb0[$];
  exp_t       sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jk_excitation_driver #(.WIDTH(8), .TOGGLE_PREF(1'b0), .MAX_RETRY(2)) u_dut (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready), .j(j), .k(k), .q_fb(q_fb), .busy(busy),
    .done(done), .err(err), .flip_cnt(flip_cnt));

  jk_excitation_driver #(.WIDTH(8), .TOGGLE_PREF(1'b1), .MAX_RETRY(2)) u_dut_t (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid_t), .tgt_data(tgt_data_t),
    .tgt_ready(tgt_ready_t), .j(j_t), .k(k_t), .q_fb(q_fb_t), .busy(busy_t),
    .done(done_t), .err(err_t), .flip_cnt(flip_cnt_t));

  // JK bank: Q+ = J&~Q | ~K&Q, reset with the driver; stuck masks readback bits to 0.
  always @(posedge clk) begin
    if (reset) begin
      bank   <= '0;
      bank_t <= '0;
    end else begin
      bank   <= (j & ~bank) | (~k & bank);
      bank_t <= (j_t & ~bank_t) | (~k_t & bank_t);
    end
  end
  assign q_fb   = bank & ~stuck;
  assign q_fb_t = bank_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic expect_resp(input int id, input bit is_err, input logic [7:0] q,
                             input logic [3:0] fc, input int c);
    exp_t e;
    e.is_err = is_err; e.q = q; e.fc = fc; e.cyc = c;
    if (id == 0) sb0.push_back(e);
    else         sb1.push_back(e);
  endtask

  task automatic mon(input int id, input logic dn, input logic er,
                     input logic [7:0] q, input logic [3:0] fc);
    exp_t e;
    int   n;
    chk($sformatf("dut%0d_done_err_exclusive", id), 32'(dn && er), 32'd0);
    if (dn || er) begin
      n = (id == 0) ? sb0.size() : sb1.size();
      if (n == 0) begin
        n_chk++;
        $display("FAIL dut%0d_unexpected_pulse: got done=%b err=%b at cycle %0d, expected none",
                 id, dn, er, cyc);
      end else begin
        if (id == 0) e = sb0.pop_front();
        else         e = sb1.pop_front();
        chk($sformatf("dut%0d_kind{done,err}", id), 32'({dn, er}),
            e.is_err ? 32'd1 : 32'd2);
        chk($sformatf("dut%0d_q_fb", id), 32'(q), 32'(e.q));
        chk($sformatf("dut%0d_flip_cnt", id), 32'(fc), 32'(e.fc));
        chk($sformatf("dut%0d_resp_cycle", id), 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done, err, q_fb, flip_cnt);
    mon(1, done_t, err_t, q_fb_t, flip_cnt_t);
  end

  task automatic offer(input int id, input logic [7:0] d, output int c0);
    int w;
    w = 0;
    while (((id == 0) ? tgt_ready : tgt_ready_t) !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 20) begin
        $display("FAIL offer_timeout: dut%0d tgt_ready got 0, expected 1", id);
        $fatal(1, "ready timeout");
      end
    end
    if (id == 0) begin tgt_valid = 1'b1; tgt_data = d; end
    else begin tgt_valid_t = 1'b1; tgt_data_t = d; end
    c0 = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2;
    reset = 1'b1; stuck = 8'h00;
    tgt_valid = 1'b0; tgt_data = 8'h00; tgt_valid_t = 1'b0; tgt_data_t = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_j", 32'(j), 32'h0);
    chk("rst_k", 32'(k), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_flip_cnt", 32'(flip_cnt), 32'h0);
    chk("rst_ready_low", 32'(tgt_ready), 32'h0);
    reset = 1'b0;
    #1 chk("rst_ready_high", 32'(tgt_ready), 32'h1);
    @(negedge clk);

    // 00 -> A5, set/reset codes
    offer(0, 8'hA5, c);
    expect_resp(0, 1'b0, 8'hA5, 4'd4, c + 3);
    @(negedge clk); tgt_valid = 1'b0;
    chk("t1_j", 32'(j), 32'hA5);
    chk("t1_k", 32'(k), 32'h00);
    chk("t1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_check_j", 32'(j), 32'h0);
    chk("t1_check_k", 32'(k), 32'h0);
    @(negedge clk);
    chk("t1_ready_at_done", 32'(tgt_ready), 32'h1);

    // A5 -> 5A, every bit changes
    offer(0, 8'h5A, c);
    expect_resp(0, 1'b0, 8'h5A, 4'd8, c + 3);
    @(negedge clk); tgt_valid = 1'b0;
    chk("t2_j", 32'(j), 32'h5A);
    chk("t2_k", 32'(k), 32'hA5);
    repeat (2) @(negedge clk);

    // 5A -> 5A, nothing to do
    offer(0, 8'h5A, c);
    expect_resp(0, 1'b0, 8'h5A, 4'd0, c + 3);
    @(negedge clk); tgt_valid = 1'b0;
    chk("t3_j", 32'(j), 32'h0);
    chk("t3_k", 32'(k), 32'h0);
    repeat (2) @(negedge clk);

    // Reset during CHECK: no pulse, bank cleared
    offer(0, 8'h3C, c);
    @(negedge clk); tgt_valid = 1'b0;
    @(negedge clk);
    chk("t5_busy_in_check", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_j", 32'(j), 32'h0);
    chk("t5_k", 32'(k), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_err", 32'(err), 32'h0);
    chk("t5_bank", 32'(q_fb), 32'h00);
    chk("t5_ready_in_reset", 32'(tgt_ready), 32'h0);
    reset = 1'b0;
    #1 chk("t5_ready_after", 32'(tgt_ready), 32'h1);
    @(negedge clk);

    // Bit 3 stuck at 0: three drives, then err
    stuck = 8'h08;
    offer(0, 8'h08, c);
    expect_resp(0, 1'b1, 8'h00, 4'd1, c + 7);
    @(negedge clk); tgt_valid = 1'b0;
    chk("t4_j_drive1", 32'(j), 32'h08);
    chk("t4_k_drive1", 32'(k), 32'h00);
    repeat (2) @(negedge clk);
    chk("t4_j_drive2", 32'(j), 32'h08);
    repeat (2) @(negedge clk);
    chk("t4_j_drive3", 32'(j), 32'h08);
    chk("t4_flip_cnt_held", 32'(flip_cnt), 32'h1);
    @(negedge clk);
    chk("t4_busy_last_check", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t4_ready_at_err", 32'(tgt_ready), 32'h1);
    @(negedge clk);
    stuck = 8'h00;

    // Back-to-back with tgt_valid held high; bank reads 08 now
    offer(0, 8'h0F, c);
    expect_resp(0, 1'b0, 8'h0F, 4'd3, c + 3);
    repeat (3) @(negedge clk);
    offer(0, 8'hF0, c2);
    chk("t6_b2b_accept_cycle", 32'(c2), 32'(c + 3));
    expect_resp(0, 1'b0, 8'hF0, 4'd8, c2 + 3);
    @(negedge clk); tgt_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Toggle-preference driver: 00 -> A5 -> 5A
    offer(1, 8'hA5, c);
    expect_resp(1, 1'b0, 8'hA5, 4'd4, c + 3);
    @(negedge clk); tgt_valid_t = 1'b0;
    chk("tt1_j", 32'(j_t), 32'hA5);
    chk("tt1_k", 32'(k_t), 32'hA5);
    repeat (2) @(negedge clk);
    offer(1, 8'h5A, c);
    expect_resp(1, 1'b0, 8'h5A, 4'd8, c + 3);
    @(negedge clk); tgt_valid_t = 1'b0;
    chk("tt2_j", 32'(j_t), 32'hFF);
    chk("tt2_k", 32'(k_t), 32'hFF);
    repeat (3) @(negedge clk);

    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
